// File: rtl/mfm_write_pkg.sv
// Shared MFM write/read constants, byte type codes and the byte-wise CCITT CRC step.
// Read and write paths both use this package.
package mfm_write_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] TYPE_DATA = 2'b00;
  localparam logic [1:0] TYPE_MARK = 2'b01;
  localparam logic [1:0] TYPE_CRC  = 2'b10;
  localparam logic [1:0] TYPE_RSVD = 2'b11;

  localparam logic [DATA_W-1:0] MARK_BYTE  = 8'hA1;
  localparam logic [15:0]       MARK_CELLS = 16'h4489;
  localparam logic [DATA_W-1:0] GAP_BYTE   = 8'h4E;
  localparam logic [15:0]       CRC_POLY   = 16'h1021;
  localparam logic [15:0]       CRC_INIT   = 16'hFFFF;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // MSB-first CCITT step over one byte.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [DATA_W-1:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/mfm_crc16.sv
// Combinational single-byte CRC-16 update.
module mfm_crc16
  import mfm_write_pkg::*;
(
  input  logic [15:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [15:0]       crc_out
);

  assign crc_out = crc16_byte(crc_in, data);

endmodule

// File: rtl/mfm_write.sv
// MFM write serializer: one-entry holding register, 16-cell shifter per byte,
// mark/CRC/gap handling and a registered write gate and flux pulse.
module mfm_write
  import mfm_write_pkg::*;
#(
  parameter int CELL_CLKS  = 24,
  parameter int PULSE_CLKS = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        type_in,
  input  logic              valid_in,
  output logic              ready,
  input  logic              write_enable,
  output logic              write_gate,
  output logic              write_pulse_l,
  output logic              underrun
);

  localparam int TW = (CELL_CLKS > 1) ? $clog2(CELL_CLKS) : 1;
  localparam logic [TW-1:0] CELL_LAST = TW'(CELL_CLKS - 1);
  localparam logic [TW-1:0] PULSE_END = TW'(PULSE_CLKS);

  function automatic logic [15:0] mfm_cells(input logic prev, input logic [DATA_W-1:0] b);
    logic [15:0] w;
    logic        p;
    p = prev;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      w[2*i+1] = ~(p | b[i]);
      w[2*i]   = b[i];
      p        = b[i];
    end
    return w;
  endfunction

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q;
  logic [3:0]        cell_q;
  logic [15:0]       cells_q;
  logic              hold_vld_q, crc2_q, prev_q, mark_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [1:0]        hold_type_q;
  logic [15:0]       crc_q, crc_base, crc_next;

  logic              accept, cell_end, byte_end, load;
  logic              ld_mark, ld_frozen, ld_crc_hi, ld_gap;
  logic [DATA_W-1:0] ld_byte;
  logic [15:0]       ld_cells;

  assign ready    = ~hold_vld_q & ~crc2_q;
  assign accept   = valid_in & ready;
  assign cell_end = (timer_q == CELL_LAST);
  assign byte_end = (state_q == ST_SHIFT) && cell_end && (cell_q == 4'd15);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE:  if (hold_vld_q) begin
                  load    = 1'b1;
                  state_d = ST_SHIFT;
                end
      ST_SHIFT: if (byte_end) begin
                  if (hold_vld_q || crc2_q || write_enable) load = 1'b1;
                  else                                      state_d = ST_IDLE;
                end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Source priority at a load: holding register, second CRC byte, gap filler.
  always_comb begin
    ld_byte   = GAP_BYTE;
    ld_mark   = 1'b0;
    ld_frozen = 1'b0;
    ld_crc_hi = 1'b0;
    if (hold_vld_q) begin
      case (hold_type_q)
        TYPE_MARK: begin
          ld_byte = MARK_BYTE;
          ld_mark = 1'b1;
        end
        TYPE_CRC: begin
          ld_byte   = crc_q[15:8];
          ld_frozen = 1'b1;
          ld_crc_hi = 1'b1;
        end
        TYPE_DATA, TYPE_RSVD: ld_byte = hold_data_q;
        default:              ld_byte = hold_data_q;
      endcase
    end else if (crc2_q) begin
      ld_byte   = crc_q[7:0];
      ld_frozen = 1'b1;
    end
    ld_gap   = load & ~hold_vld_q & ~crc2_q;
    crc_base = (ld_mark && !mark_q) ? CRC_INIT : crc_q;
    ld_cells = ld_mark ? MARK_CELLS : mfm_cells(prev_q, ld_byte);
  end

  mfm_crc16 u_crc (
    .crc_in  (crc_base),
    .data    (ld_byte),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hold_vld_q    <= 1'b0;
      crc2_q        <= 1'b0;
      crc_q         <= CRC_INIT;
      prev_q        <= 1'b0;
      mark_q        <= 1'b0;
      timer_q       <= '0;
      cell_q        <= '0;
      write_gate    <= 1'b0;
      write_pulse_l <= 1'b1;
      underrun      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_vld_q    <= accept | (hold_vld_q & ~load);
      // Outputs trail the internal cell state by one clock.
      write_gate    <= (state_q == ST_SHIFT);
      write_pulse_l <= ~((state_q == ST_SHIFT) && cells_q[15] && (timer_q < PULSE_END));
      underrun      <= ld_gap;
      if (load) begin
        timer_q <= '0;
        cell_q  <= '0;
        prev_q  <= ld_byte[0];
        mark_q  <= ld_mark;
        crc2_q  <= ld_crc_hi;
        if (!ld_frozen) crc_q <= crc_next;
      end else if (state_q == ST_SHIFT) begin
        if (state_d == ST_IDLE) begin
          timer_q <= '0;
          cell_q  <= '0;
          prev_q  <= 1'b0;
          mark_q  <= 1'b0;
        end else if (cell_end) begin
          timer_q <= '0;
          cell_q  <= cell_q + 4'd1;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data_q <= data_in;
      hold_type_q <= type_in;
    end
    if (load)                               cells_q <= ld_cells;
    else if (state_q == ST_SHIFT && cell_end) cells_q <= {cells_q[14:0], 1'b0};
  end

endmodule

// File: tb/tb_mfm_write.sv
// Bench for mfm_write: decodes the flux pulse train back into 16-cell words and
// checks them against constants and a burst-level MFM/CRC reference model.
`timescale 1ns/1ps
module tb_mfm_write;
  import mfm_write_pkg::*;

  localparam int CELL  = 24;
  localparam int PULSE = 12;
  localparam int BYTEC = 16 * CELL;

  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] data_in = '0;
  logic [1:0] type_in = '0;
  logic       valid_in = 1'b0, write_enable = 1'b0;
  logic       ready, write_gate, write_pulse_l, underrun;

  mfm_write #(.CELL_CLKS(CELL), .PULSE_CLKS(PULSE)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .type_in(type_in), .valid_in(valid_in),
    .ready(ready), .write_enable(write_enable), .write_gate(write_gate),
    .write_pulse_l(write_pulse_l), .underrun(underrun)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flux monitor: one cell sampled at the first clock of each cell after gate rise.
  logic [15:0] mon_q[$];
  int          len_q[$], pul_q[$];
  int          g = 0, nc = 0, ph = 0, pcount = 0, bursts = 0, und_cnt = 0, pw_err = 0, rise_cyc = 0;
  logic [15:0] sh = '0;
  logic        cur = 1'b0, prev_pl = 1'b1;
  initial forever begin
    @(negedge clk);
    if (write_gate === 1'b1) begin
      if (g == 0) rise_cyc = cyc;
      ph = g % CELL;
      if (ph == 0) begin
        cur = ~write_pulse_l;
        sh  = {sh[14:0], cur};
        nc++;
        if (nc == 16) begin mon_q.push_back(sh); nc = 0; end
      end
      if (write_pulse_l !== ~(cur && ph < PULSE)) pw_err++;
      g++;
    end else begin
      if (write_pulse_l !== 1'b1) pw_err++;
      if (g > 0) begin
        len_q.push_back(g); pul_q.push_back(pcount);
        bursts++; g = 0; nc = 0; pcount = 0;
      end
    end
    if (prev_pl && !write_pulse_l) pcount++;
    prev_pl = write_pulse_l;
    if (underrun === 1'b1) und_cnt++;
  end

  function automatic logic [15:0] pop_word();
    return (mon_q.size() > 0) ? mon_q.pop_front() : 16'h0000;
  endfunction
  function automatic int pop_len();
    return (len_q.size() > 0) ? len_q.pop_front() : -1;
  endfunction
  function automatic int pop_pul();
    return (pul_q.size() > 0) ? pul_q.pop_front() : -1;
  endfunction
  function automatic logic [7:0] data_of(input logic [15:0] w);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = w[2*i];
    return b;
  endfunction

  // Reference CRC: shift-register form with the byte xored into the top.
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  typedef struct { logic [7:0] b; bit mark; } item_t;
  item_t       exp_items[$];
  logic [15:0] m_crc  = 16'hFFFF;
  bit          m_mark = 1'b0;

  task automatic model_push(input logic [1:0] t, input logic [7:0] d);
    if (t == TYPE_MARK) begin
      if (!m_mark) m_crc = 16'hFFFF;
      m_crc = ref_crc(m_crc, 8'hA1);
      exp_items.push_back('{8'hA1, 1'b1});
      m_mark = 1'b1;
    end else if (t == TYPE_CRC) begin
      exp_items.push_back('{m_crc[15:8], 1'b0});
      exp_items.push_back('{m_crc[7:0], 1'b0});
      m_mark = 1'b0;
    end else begin
      m_crc = ref_crc(m_crc, d);
      exp_items.push_back('{d, 1'b0});
      m_mark = 1'b0;
    end
  endtask

  // Expected cells for the whole burst: the data bit stream with clocks between.
  task automatic compare_burst(input string tag);
    logic        p;
    logic [15:0] w;
    p = 1'b0;
    check({tag, "_len"}, pop_len(), exp_items.size() * BYTEC);
    void'(pop_pul());
    for (int k = 0; k < exp_items.size(); k++) begin
      w = '0;
      for (int j = 7; j >= 0; j--) begin
        logic c;
        c = !(p || exp_items[k].b[j]);
        if (exp_items[k].mark && j == 2) c = 1'b0;
        w = {w[13:0], c, exp_items[k].b[j]};
        p = exp_items[k].b[j];
      end
      check($sformatf("%s_w%0d", tag, k), pop_word(), w);
    end
    exp_items.delete();
    m_mark = 1'b0;
  endtask

  int acc_cyc = 0;
  task automatic send(input logic [1:0] t, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 4000) begin @(negedge clk); n++; end
    if (!ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: ready got 0 expected 1");
    end else begin
      valid_in = 1'b1; type_in = t; data_in = d;
      @(posedge clk);
      #1 acc_cyc = cyc; valid_in = 1'b0;
    end
  endtask

  task automatic wait_burst(input int target);
    int n;
    n = 0;
    while (bursts < target && n < 20000) begin @(negedge clk); n++; end
    @(negedge clk);
    if (bursts < target) begin
      n_cmp++; n_bad++;
      $display("FAIL burst_timeout: got %0d bursts expected %0d", bursts, target);
    end
  endtask

  typedef struct { logic [1:0] t; logic [7:0] d; logic [15:0] cells; int pulses; } vec_t;
  vec_t        vt[6];
  int          b0, u0, nb, n;
  logic [7:0]  bytes[10];
  logic [15:0] rc;

  initial begin
    vt[0] = '{TYPE_MARK, 8'h00, 16'h4489, 5};
    vt[1] = '{TYPE_DATA, 8'h00, 16'hAAAA, 8};
    vt[2] = '{TYPE_DATA, 8'hFF, 16'h5555, 8};
    vt[3] = '{TYPE_DATA, 8'h01, 16'hAAA9, 8};
    vt[4] = '{TYPE_DATA, 8'h4E, 16'h9254, 6};
    vt[5] = '{TYPE_RSVD, 8'hFF, 16'h5555, 8};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_gate", write_gate, 0);
    check("rst_pulse_l", write_pulse_l, 1);
    check("rst_underrun", underrun, 0);

    // Single bytes from idle: cells, pulse count, gate width, latency.
    for (int i = 0; i < 6; i++) begin
      b0 = bursts;
      send(vt[i].t, vt[i].d);
      wait_burst(b0 + 1);
      check($sformatf("vec%0d_latency", i), rise_cyc - acc_cyc, 2);
      check($sformatf("vec%0d_cells", i), pop_word(), vt[i].cells);
      check($sformatf("vec%0d_len", i), pop_len(), BYTEC);
      check($sformatf("vec%0d_pulses", i), pop_pul(), vt[i].pulses);
    end

    // Previous data bit carries across the byte boundary.
    b0 = bursts;
    send(TYPE_DATA, 8'h01);
    send(TYPE_DATA, 8'h00);
    wait_burst(b0 + 1);
    check("carry_w0", pop_word(), 16'hAAA9);
    check("carry_w1", pop_word(), 16'h2AAA);
    check("carry_len", pop_len(), 2 * BYTEC);
    check("carry_pulses", pop_pul(), 15);

    // Underrun inserts one gap byte with no timing hole.
    write_enable = 1'b1;
    b0 = bursts; u0 = und_cnt;
    send(TYPE_DATA, 8'h00);
    n = 0;
    while (und_cnt == u0 && n < 2000) begin @(negedge clk); n++; end
    write_enable = 1'b0;
    wait_burst(b0 + 1);
    check("gap_underrun_cnt", und_cnt - u0, 1);
    check("gap_w0", pop_word(), 16'hAAAA);
    check("gap_w1", pop_word(), 16'h9254);
    check("gap_len", pop_len(), 2 * BYTEC);
    void'(pop_pul());

    // Back-to-back bytes with the holder refilled each time.
    b0 = bursts;
    send(TYPE_DATA, 8'h12); model_push(TYPE_DATA, 8'h12);
    send(TYPE_DATA, 8'h34); model_push(TYPE_DATA, 8'h34);
    @(negedge clk);
    check("b2b_ready_full", ready, 0);
    send(TYPE_DATA, 8'h56); model_push(TYPE_DATA, 8'h56);
    wait_burst(b0 + 1);
    compare_burst("b2b");

    // ID field with CRC; decoded stream must check to zero.
    b0 = bursts;
    send(TYPE_MARK, 8'h00); send(TYPE_MARK, 8'h00); send(TYPE_MARK, 8'h00);
    send(TYPE_DATA, 8'hFE); send(TYPE_DATA, 8'h00); send(TYPE_DATA, 8'h00);
    send(TYPE_DATA, 8'h01); send(TYPE_DATA, 8'h02); send(TYPE_CRC, 8'h00);
    repeat (500) @(negedge clk);
    check("crc1_ready", ready, 0);
    wait_burst(b0 + 1);
    check("id_len", pop_len(), 10 * BYTEC);
    void'(pop_pul());
    rc = 16'hFFFF;
    for (int k = 0; k < 10; k++) begin
      logic [15:0] w;
      w = pop_word();
      if (k == 0) check("id_mark_cells", w, 16'h4489);
      bytes[k] = data_of(w);
      rc = ref_crc(rc, bytes[k]);
    end
    check("id_crc_hi", bytes[8], 8'hCA);
    check("id_crc_lo", bytes[9], 8'h6F);
    check("id_crc_residue", rc, 16'h0000);

    // Reset in cell 7 aborts the byte at once.
    send(TYPE_MARK, 8'h00);
    n = 0;
    while (write_gate !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (7 * CELL + 3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_gate", write_gate, 0);
    check("abort_pulse_l", write_pulse_l, 1);
    check("abort_ready", ready, 1);
    @(negedge clk);
    mon_q.delete(); len_q.delete(); pul_q.delete();
    exp_items.delete(); m_mark = 1'b0; m_crc = 16'hFFFF;
    b0 = bursts;
    send(TYPE_MARK, 8'h00); model_push(TYPE_MARK, 8'h00);
    send(TYPE_DATA, 8'h00); model_push(TYPE_DATA, 8'h00);
    send(TYPE_CRC, 8'h00);  model_push(TYPE_CRC, 8'h00);
    wait_burst(b0 + 1);
    compare_burst("restart");

    // Randomized bursts, each opened by a mark.
    for (int r = 0; r < 3; r++) begin
      logic [1:0] t;
      logic [7:0] d;
      b0 = bursts;
      nb = 4 + int'($urandom_range(5));
      for (int k = 0; k < nb; k++) begin
        case ($urandom_range(7))
          3:       t = TYPE_RSVD;
          4, 5:    t = TYPE_MARK;
          6:       t = TYPE_CRC;
          default: t = TYPE_DATA;
        endcase
        if (k == 0) t = TYPE_MARK;
        d = 8'($urandom);
        send(t, d);
        model_push(t, d);
      end
      wait_burst(b0 + 1);
      compare_burst($sformatf("rnd%0d", r));
    end

    check("pulse_shape_errors", pw_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
